// File: rtl/game_pkg.sv
// Shared game types and constants for the score link: game/mode enums,
// receiver FSM states, frame marker and winning score.
package game_pkg;

    typedef enum logic [1:0] {MENU, KEEPER, SHOOTER, GAME_OVER} g_state;
    typedef enum logic       {SOLO, MULTI} g_mode;

    // state  | meaning
    // IDLE   | not in a multiplayer round, everything held cleared
    // SYNC   | waiting for the first accepted frame from the remote side
    // LINKED | frames arriving within the timeout window
    // LOST   | timeout expired, waiting for any accepted frame
    typedef enum logic [1:0] {IDLE, SYNC, LINKED, LOST} rx_state_t;

    localparam logic [2:0] SCORE_MARKER = 3'b111;
    localparam logic [2:0] WIN_SCORE    = 3'd5;

endpackage

// File: rtl/score_frame_check.sv
// Combinational plausibility check of a remote score frame
// {flag, is_scored, score[2:0], marker[2:0]} against the current remote score.
module score_frame_check
    import game_pkg::*;
(
    input  logic [7:0] i_frame,
    input  logic [2:0] i_remote_score,
    output logic       o_valid
);

    logic [2:0] w_score;
    logic [2:0] w_marker;

    assign w_score  = i_frame[5:3];
    assign w_marker = i_frame[2:0];

    // The remote score may only hold or advance by one point per frame.
    assign o_valid = (w_marker == SCORE_MARKER)
                  && (w_score <= WIN_SCORE)
                  && (w_score >= i_remote_score)
                  && ({1'b0, w_score} <= ({1'b0, i_remote_score} + 4'd1));

endmodule

// File: rtl/score_receiver.sv
// Remote score receiver with link supervision. Optional SCORE_RX_CONFIRM_EN
// accepts a valid frame only when it repeats the previous valid frame.
module score_receiver
    import game_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  g_state     game_state,
    input  g_mode      game_mode,
    input  logic [7:0] data_received,
    input  logic       rx_valid,
    output logic       remote_round_done,
    output logic       remote_is_scored,
    output logic [2:0] remote_score,
    output logic       link_ok,
    output logic       frame_error,
    output logic       match_end,
    output logic       match_result
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_flag_last;
    logic          r_round_done;
    logic          r_is_scored;
    logic [2:0]    r_score;
    logic          r_frame_error;
    logic          r_match_end;

    logic w_active;
    logic w_rx_live;
    logic w_valid;
    logic w_accept;
    logic w_reject;

    assign w_active  = (game_mode == MULTI) && ((game_state == KEEPER) || (game_state == SHOOTER));
    assign w_rx_live = rx_valid && w_active && (r_state != IDLE);

    score_frame_check u_check (
        .i_frame        (data_received),
        .i_remote_score (r_score),
        .o_valid        (w_valid)
    );

`ifdef SCORE_RX_CONFIRM_EN
    logic [7:0] r_prev_frame;
    logic       r_prev_vld;

    assign w_accept = w_rx_live && w_valid && r_prev_vld && (data_received == r_prev_frame);

    always_ff @(posedge clk) begin
        if (rst || !w_active) begin
            r_prev_frame <= 8'd0;
            r_prev_vld   <= 1'b0;
        end else if (w_rx_live && w_valid) begin
            r_prev_frame <= data_received;
            r_prev_vld   <= 1'b1;
        end
    end
`else
    assign w_accept = w_rx_live && w_valid;
`endif

    // An unconfirmed but valid frame is not an error.
    assign w_reject = w_rx_live && !w_valid;

    always_ff @(posedge clk) begin
        if (rst || !w_active) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_flag_last   <= 1'b0;
            r_round_done  <= 1'b0;
            r_is_scored   <= 1'b0;
            r_score       <= 3'd0;
            r_frame_error <= 1'b0;
            r_match_end   <= 1'b0;
        end else begin
            r_round_done  <= 1'b0;
            r_frame_error <= w_reject;

            case (r_state)
                IDLE:        r_state <= SYNC;
                SYNC, LOST:  if (w_accept) r_state <= LINKED;
                LINKED:      if (!w_accept && (r_cnt == CNT_LAST)) r_state <= LOST;
                default:     r_state <= IDLE;
            endcase

            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_accept) begin
                r_flag_last  <= data_received[7];
                r_round_done <= data_received[7] && !r_flag_last;
                r_is_scored  <= data_received[6];
                if (!r_match_end) begin
                    r_score <= data_received[5:3];
                end
                if (data_received[5:3] == WIN_SCORE) begin
                    r_match_end <= 1'b1;
                end
            end
        end
    end

    assign remote_round_done = r_round_done;
    assign remote_is_scored  = r_is_scored;
    assign remote_score      = r_score;
    assign link_ok           = (r_state == LINKED);
    assign frame_error       = r_frame_error;
    assign match_end         = r_match_end;
    // The remote reaching the winning score always means the local player lost.
    assign match_result      = 1'b0;

endmodule

// File: doc/score_receiver.md
SCORE_RECEIVER -- requirements
Module: score_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65_000_000, SHALL set the number of clk cycles without an accepted frame before the link is declared lost.
REQ-002 Port clk, input, 1 bit, SHALL be the single system clock.
REQ-003 Port rst, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-004 Port game_state, input, g_state, SHALL be the current game state; only KEEPER and SHOOTER are active states.
REQ-005 Port game_mode, input, g_mode, SHALL select the mode; SOLO or MULTI.
REQ-006 Port data_received, input, 8 bits, SHALL carry the remote score frame {flag, is_scored, score[2:0], marker[2:0]}.
REQ-007 Port rx_valid, input, 1 bit, SHALL be a one-cycle strobe qualifying data_received.
REQ-008 Port remote_round_done, output, 1 bit, SHALL be a one-cycle pulse on an accepted 0->1 transition of the frame flag.
REQ-009 Port remote_is_scored, output, 1 bit, SHALL hold is_scored from the last accepted frame.
REQ-010 Port remote_score, output, 3 bits, SHALL hold the last accepted remote score.
REQ-011 Port link_ok, output, 1 bit, SHALL be high while the FSM is in LINKED.
REQ-012 Port frame_error, output, 1 bit, SHALL pulse for one cycle per rejected frame.
REQ-013 Port match_end, output, 1 bit, SHALL be high once remote_score equals 5.
REQ-014 Port match_result, output, 1 bit, SHALL be 0 (match lost by the player) whenever match_end is high, else 0.

Function
REQ-015 The FSM SHALL have the states IDLE, SYNC, LINKED and LOST.
REQ-016 From any state, game_mode != MULTI or game_state outside {KEEPER, SHOOTER} SHALL force IDLE next cycle and clear remote_score, remote_is_scored, the flag history, match_end and the timeout counter.
REQ-017 IDLE SHALL go to SYNC when game_mode == MULTI and game_state is in {KEEPER, SHOOTER}.
REQ-018 SYNC and LOST SHALL go to LINKED on the first accepted frame.
REQ-019 LINKED SHALL go to LOST when the timeout counter reaches TIMEOUT_CYCLES-1.
REQ-020 The timeout counter SHALL reset on every accepted frame and SHALL saturate, never wrap.
REQ-021 A frame SHALL be valid only if marker == 3'b111, score <= 5, score >= remote_score and score <= remote_score+1.
REQ-022 An invalid frame SHALL be dropped with no state or output update except frame_error, one cycle after the rx_valid cycle.
REQ-023 An accepted frame SHALL update the registered outputs on the clk edge after the rx_valid cycle, a latency of 1 cycle.
REQ-024 remote_round_done SHALL pulse only when the accepted flag is 1 and the previous accepted flag was 0.
REQ-025 Repeated frames with flag=1 SHALL NOT produce a further pulse.
REQ-026 After entering SYNC, the first accepted frame with flag=1 SHALL pulse remote_round_done.
REQ-027 match_end SHALL be sticky until IDLE or rst, and later frames SHALL NOT change remote_score once match_end is high.
REQ-028 rx_valid in IDLE SHALL be ignored, with no frame_error.

Reset
REQ-029 rst SHALL force IDLE and drive every output and internal register to 0, including remote_score = 3'd0.
REQ-030 rst SHALL take priority over rx_valid in the same cycle.
REQ-031 rst asserted mid-frame or mid-timeout SHALL discard all history.

Configuration
REQ-032 With SCORE_RX_CONFIRM_EN defined, a valid frame SHALL be accepted only when it equals the previous valid frame received, which makes the latency 1 cycle after the second matching strobe.
REQ-033 Under SCORE_RX_CONFIRM_EN, a single valid frame that is not yet confirmed SHALL NOT raise frame_error.
REQ-034 Without SCORE_RX_CONFIRM_EN, every valid frame SHALL be accepted immediately and the confirmation register SHALL not be built.

Structure
REQ-035 g_state, g_mode, the FSM state enum, the constant SCORE_MARKER = 3'b111 and the constant WIN_SCORE = 5 SHALL reside in game_pkg.
REQ-036 Frame validation SHALL be a combinational sub-module, score_frame_check, taking the frame and remote_score and returning valid.

Verification
REQ-037 MULTI, KEEPER, frame 8'h97 (flag=1, is_scored=0, score=2), remote_score=1 -> accepted; next cycle remote_score=2, remote_round_done pulses, link_ok=1.
REQ-038 Frame 8'h0F then 8'h2F (score 1 -> 5, jump of 4) -> the second frame is rejected, frame_error pulses once, remote_score stays 1.
REQ-039 Frame with marker 3'b101 (8'h0D) -> frame_error pulses, no update.
REQ-040 Frames 8'hAF x3 then 8'h2F -> remote_round_done pulses once.
REQ-041 Frames raising score 4 -> 5 -> match_end=1, match_result=0, and a later 8'h2F does not change remote_score.
REQ-042 No frame for TIMEOUT_CYCLES=16 -> link_ok drops at cycle 16; a valid frame then restores LINKED; switching to SOLO clears all outputs next cycle.
